// File: rtl/spi_seq_pkg.sv
// Shared types and defaults for the SPI transaction sequencer.
// Holds the FSM state encoding, byte width and default sizing.
package spi_seq_pkg;

    localparam int BYTE_W      = 8;
    localparam int SEQ_DEPTH   = 4;
    localparam int SEQ_TIMEOUT = 1024;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_DONE,
        STORE
    } seq_state_t;

endpackage

// File: rtl/spi_txn_sequencer_if.sv
// Host-side and SPI-master-side signal bundle of the sequencer.
// The slave modport is the sequencer's view; master is the environment's.
interface spi_txn_sequencer_if;
    import spi_seq_pkg::*;

    logic              wr_valid;
    logic [BYTE_W-1:0] wr_data;
    logic              wr_ready;
    logic              rd_valid;
    logic [BYTE_W-1:0] rd_data;
    logic              rd_ready;
    logic              spi_start;
    logic [BYTE_W-1:0] spi_tx_data;
    logic              spi_done;
    logic [BYTE_W-1:0] spi_rx_data;
    logic              busy;
    logic              timeout_err;

    modport slave (
        input  wr_valid, wr_data, rd_ready, spi_done, spi_rx_data,
        output wr_ready, rd_valid, rd_data, spi_start, spi_tx_data,
        output busy, timeout_err
    );

    modport master (
        output wr_valid, wr_data, rd_ready, spi_done, spi_rx_data,
        input  wr_ready, rd_valid, rd_data, spi_start, spi_tx_data,
        input  busy, timeout_err
    );

endinterface

// File: rtl/spi_seq_fifo.sv
// Byte FIFO with wrap-around pointers; the extra pointer MSB separates full from empty.
// Head is read combinationally from storage; push/pop are ignored when full/empty.
module spi_seq_fifo
    import spi_seq_pkg::*;
#(
    parameter int DEPTH = SEQ_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic [BYTE_W-1:0] i_data,
    input  logic              i_pop,
    output logic [BYTE_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [BYTE_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wp;
    logic [AW:0]       r_rp;
    logic              w_push;
    logic              w_pop;

    assign o_empty = (r_wp == r_rp);
    assign o_full  = (r_wp[AW] != r_rp[AW]) &&
                     (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_data  = r_mem[r_rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp[AW-1:0]] <= i_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
        end
    end

endmodule

// File: rtl/spi_txn_sequencer.sv
// Moves host bytes through an SPI master one at a time, queueing replies.
// Define SPI_SEQ_TIMEOUT_EN to enable the WAIT_DONE watchdog.
module spi_txn_sequencer
    import spi_seq_pkg::*;
#(
    parameter int DEPTH          = SEQ_DEPTH,
    parameter int TIMEOUT_CYCLES = SEQ_TIMEOUT
) (
    input  logic               clk,
    input  logic               reset,
    spi_txn_sequencer_if.slave bus
);
`ifdef SPI_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    seq_state_t        r_state;
    seq_state_t        w_state_nx;
    logic [BYTE_W-1:0] r_tx_data;
    logic              r_start;
    logic [BYTE_W-1:0] r_rx_byte;
    logic [TW-1:0]     r_to_cnt;
    logic              r_to_err;

    logic              w_tx_push;
    logic              w_tx_pop;
    logic [BYTE_W-1:0] w_tx_head;
    logic              w_tx_full;
    logic              w_tx_empty;
    logic              w_rx_push;
    logic              w_rx_pop;
    logic              w_rx_full;
    logic              w_rx_empty;
    logic              w_to_hit;

    assign w_tx_push       = bus.wr_valid & ~w_tx_full;
    assign w_rx_pop        = bus.rd_ready & ~w_rx_empty;
    assign bus.wr_ready    = ~w_tx_full;
    assign bus.rd_valid    = ~w_rx_empty;
    assign bus.spi_start   = r_start;
    assign bus.spi_tx_data = r_tx_data;
    assign bus.busy        = (r_state != IDLE);
    assign bus.timeout_err = TO_EN & r_to_err;

    spi_seq_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_tx_push),
        .i_data  (bus.wr_data),
        .i_pop   (w_tx_pop),
        .o_data  (w_tx_head),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty)
    );

    spi_seq_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_rx_push),
        .i_data  (r_rx_byte),
        .i_pop   (w_rx_pop),
        .o_data  (bus.rd_data),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty)
    );

    // A transfer only starts when its reply is guaranteed a slot in RX.
    always_comb begin
        w_state_nx = r_state;
        w_tx_pop   = 1'b0;
        w_rx_push  = 1'b0;
        w_to_hit   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!w_tx_empty && !w_rx_full) w_state_nx = LOAD;
            end
            LOAD: begin
                w_tx_pop   = 1'b1;
                w_state_nx = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (bus.spi_done) begin
                    w_state_nx = STORE;
                end else if (TO_EN && r_to_cnt == TO_LAST) begin
                    w_to_hit   = 1'b1;
                    w_state_nx = STORE;
                end
            end
            STORE: begin
                w_rx_push  = 1'b1;
                w_state_nx = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_tx_data <= '0;
            r_start   <= 1'b0;
            r_rx_byte <= '0;
            r_to_cnt  <= '0;
            r_to_err  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_start <= w_tx_pop;
            if (w_tx_pop) r_tx_data <= w_tx_head;
            if (r_state == WAIT_DONE && bus.spi_done)
                r_rx_byte <= bus.spi_rx_data;
            else if (w_to_hit)
                r_rx_byte <= 8'hFF;
            if (r_state == WAIT_DONE) r_to_cnt <= r_to_cnt + TW'(1);
            else                      r_to_cnt <= '0;
            if (w_to_hit) r_to_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Directed bench for spi_txn_sequencer with a behavioural SPI master model.
// Build with SPI_SEQ_TIMEOUT_EN to exercise the watchdog path.
module tb_spi_txn_sequencer;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    int   n_start;
    logic [7:0] last_tx;

    bit         m_en;
    int         m_lat;
    bit         m_xor;
    logic [7:0] m_fixed;
    bit         m_pend;
    int         m_cnt;
    logic [7:0] m_cap;
    logic       m_done;
    logic [7:0] m_rx;
    logic       inj_done;
    logic [7:0] inj_data;

    spi_txn_sequencer_if bus();

    spi_txn_sequencer #(
        .DEPTH          (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    assign bus.spi_done    = m_done | inj_done;
    assign bus.spi_rx_data = inj_done ? inj_data : m_rx;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Start pulses are sampled at the rising edge, so a stretched pulse counts twice.
    always @(posedge clk) begin
        if (bus.spi_start) begin
            n_start = n_start + 1;
            last_tx = bus.spi_tx_data;
        end
    end

    always @(negedge clk) begin
        m_done = 1'b0;
        if (m_pend) begin
            if (m_cnt <= 1) begin
                m_done = 1'b1;
                m_rx   = m_xor ? ~m_cap : m_fixed;
                m_pend = 1'b0;
            end else begin
                m_cnt = m_cnt - 1;
            end
        end
        if (m_en && bus.spi_start) begin
            m_pend = 1'b1;
            m_cnt  = m_lat;
            m_cap  = bus.spi_tx_data;
        end
    end

    task automatic push_byte(input logic [7:0] d);
        bus.wr_valid = 1'b1;
        bus.wr_data  = d;
        @(negedge clk);
        bus.wr_valid = 1'b0;
    endtask

    task automatic pop_once();
        bus.rd_ready = 1'b1;
        @(negedge clk);
        bus.rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #2;
        checks++;
        if (bus.spi_start !== 1'b0) begin
            errors++; $display("FAIL rst_start: got %b want 0", bus.spi_start);
        end
        checks++;
        if (bus.spi_tx_data !== 8'h00) begin
            errors++; $display("FAIL rst_txdata: got %h want 00", bus.spi_tx_data);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL rst_busy: got %b want 0", bus.busy);
        end
        checks++;
        if (bus.rd_valid !== 1'b0) begin
            errors++; $display("FAIL rst_rdvalid: got %b want 0", bus.rd_valid);
        end
        checks++;
        if (bus.wr_ready !== 1'b1) begin
            errors++; $display("FAIL rst_wrready: got %b want 1", bus.wr_ready);
        end
        checks++;
        if (bus.timeout_err !== 1'b0) begin
            errors++; $display("FAIL rst_tmo: got %b want 0", bus.timeout_err);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || n_start != 0) begin
            errors++;
            $display("FAIL idle_after_rst: busy=%b starts=%0d want 0/0", bus.busy, n_start);
        end
    endtask

    task automatic test_single();
        int base;
        base = n_start;
        m_en = 1'b1; m_xor = 1'b0; m_fixed = 8'h3C; m_lat = 3;
        push_byte(8'hA5);
        for (int i = 0; i < 50 && !bus.rd_valid; i++) @(negedge clk);
        checks++;
        if (bus.rd_valid !== 1'b1) begin
            errors++; $display("FAIL single_rdvalid: got %b want 1", bus.rd_valid);
        end
        checks++;
        if (n_start != base + 1) begin
            errors++; $display("FAIL single_starts: got %0d want %0d", n_start, base + 1);
        end
        checks++;
        if (last_tx !== 8'hA5 || bus.spi_tx_data !== 8'hA5) begin
            errors++;
            $display("FAIL single_txdata: got %h/%h want a5", last_tx, bus.spi_tx_data);
        end
        checks++;
        if (bus.rd_data !== 8'h3C) begin
            errors++; $display("FAIL single_rddata: got %h want 3c", bus.rd_data);
        end
        pop_once();
        checks++;
        if (bus.rd_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: rdv=%b busy=%b want 0/0", bus.rd_valid, bus.busy);
        end
    endtask

    task automatic test_done_in_idle();
        int base;
        base = n_start;
        inj_data = 8'h5A;
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.rd_valid !== 1'b0 || bus.busy !== 1'b0 || n_start != base) begin
            errors++;
            $display("FAIL idle_done: rdv=%b busy=%b starts=%0d want 0/0/%0d",
                     bus.rd_valid, bus.busy, n_start, base);
        end
    endtask

    task automatic test_fill_stall();
        int base;
        logic [7:0] exp_q [4];
        exp_q = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
        base = n_start;
        m_en = 1'b1; m_xor = 1'b1; m_lat = 20;
        bus.rd_ready = 1'b0;
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        checks++;
        if (bus.wr_ready !== 1'b1) begin
            errors++; $display("FAIL fill_ready_mid: got %b want 1", bus.wr_ready);
        end
        push_byte(8'h44);
        push_byte(8'h55);
        checks++;
        if (bus.wr_ready !== 1'b0) begin
            errors++; $display("FAIL fill_ready_full: got %b want 0", bus.wr_ready);
        end
        for (int i = 0; i < 400 && !(n_start == base + 4 && !bus.busy); i++)
            @(negedge clk);
        repeat (30) @(negedge clk);
        checks++;
        if (n_start != base + 4 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL fill_stall: starts=%0d busy=%b want %0d/0",
                     n_start, bus.busy, base + 4);
        end
        checks++;
        if (bus.wr_ready !== 1'b1 || bus.rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL fill_flags: wrr=%b rdv=%b want 1/1", bus.wr_ready, bus.rd_valid);
        end
        checks++;
        if (bus.rd_data !== 8'hEE) begin
            errors++; $display("FAIL fill_head: got %h want ee", bus.rd_data);
        end
        pop_once();
        for (int i = 0; i < 100 && n_start != base + 5; i++) @(negedge clk);
        checks++;
        if (n_start != base + 5 || last_tx !== 8'h55) begin
            errors++;
            $display("FAIL fill_resume: starts=%0d tx=%h want %0d/55",
                     n_start, last_tx, base + 5);
        end
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 200 && !(bus.rd_valid && !bus.busy); i++)
                @(negedge clk);
            checks++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_q[k]) begin
                errors++;
                $display("FAIL fill_drain%0d: rdv=%b data=%h want 1/%h",
                         k, bus.rd_valid, bus.rd_data, exp_q[k]);
            end
            pop_once();
        end
        checks++;
        if (bus.rd_valid !== 1'b0) begin
            errors++; $display("FAIL fill_empty: got %b want 0", bus.rd_valid);
        end
    endtask

`ifdef SPI_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int base;
        base = n_start;
        m_en = 1'b0;
        push_byte(8'hC1);
        push_byte(8'hC2);
        for (int i = 0; i < 20 && n_start != base + 1; i++) @(negedge clk);
        repeat (14) @(negedge clk);
        checks++;
        if (bus.timeout_err !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL tmo_early: err=%b busy=%b want 0/1", bus.timeout_err, bus.busy);
        end
        @(negedge clk);
        checks++;
        if (bus.timeout_err !== 1'b1) begin
            errors++; $display("FAIL tmo_set: got %b want 1", bus.timeout_err);
        end
        for (int i = 0; i < 10 && !bus.rd_valid; i++) @(negedge clk);
        checks++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'hFF) begin
            errors++;
            $display("FAIL tmo_ff: rdv=%b data=%h want 1/ff", bus.rd_valid, bus.rd_data);
        end
        pop_once();
        for (int i = 0; i < 20 && n_start != base + 2; i++) @(negedge clk);
        checks++;
        if (n_start != base + 2 || last_tx !== 8'hC2) begin
            errors++;
            $display("FAIL tmo_next: starts=%0d tx=%h want %0d/c2",
                     n_start, last_tx, base + 2);
        end
        for (int i = 0; i < 60 && !bus.rd_valid; i++) @(negedge clk);
        checks++;
        if (bus.rd_data !== 8'hFF || bus.timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL tmo_sticky: data=%h err=%b want ff/1",
                     bus.rd_data, bus.timeout_err);
        end
        pop_once();
    endtask
`else
    task automatic test_no_timeout();
        m_en = 1'b0;
        push_byte(8'h3E);
        repeat (40) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1 || bus.timeout_err !== 1'b0 || bus.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL notmo_wait: busy=%b err=%b rdv=%b want 1/0/0",
                     bus.busy, bus.timeout_err, bus.rd_valid);
        end
        inj_data = 8'hE3;
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        for (int i = 0; i < 10 && !bus.rd_valid; i++) @(negedge clk);
        checks++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'hE3) begin
            errors++;
            $display("FAIL notmo_done: rdv=%b data=%h want 1/e3", bus.rd_valid, bus.rd_data);
        end
        pop_once();
    endtask
`endif

    task automatic test_reset_mid();
        int base;
        base = n_start;
        m_en = 1'b1; m_xor = 1'b1; m_lat = 20;
        push_byte(8'h66);
        push_byte(8'h77);
        for (int i = 0; i < 20 && n_start != base + 1; i++) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1 || n_start != base + 1) begin
            errors++;
            $display("FAIL mid_inflight: busy=%b starts=%0d want 1/%0d",
                     bus.busy, n_start, base + 1);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.spi_start !== 1'b0 || bus.spi_tx_data !== 8'h00) begin
            errors++;
            $display("FAIL mid_rst_out: busy=%b start=%b tx=%h want 0/0/00",
                     bus.busy, bus.spi_start, bus.spi_tx_data);
        end
        checks++;
        if (bus.rd_valid !== 1'b0 || bus.wr_ready !== 1'b1 || bus.timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_flags: rdv=%b wrr=%b err=%b want 0/1/0",
                     bus.rd_valid, bus.wr_ready, bus.timeout_err);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if (n_start != base + 1 || bus.rd_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_quiet: starts=%0d rdv=%b busy=%b want %0d/0/0",
                     n_start, bus.rd_valid, bus.busy, base + 1);
        end
    endtask

    task automatic test_recover();
        int base;
        base = n_start;
        m_en = 1'b1; m_xor = 1'b1; m_lat = 3;
        push_byte(8'h99);
        for (int i = 0; i < 50 && !bus.rd_valid; i++) @(negedge clk);
        checks++;
        if (n_start != base + 1 || bus.rd_data !== 8'h66) begin
            errors++;
            $display("FAIL recover: starts=%0d data=%h want %0d/66",
                     n_start, bus.rd_data, base + 1);
        end
        pop_once();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        errors = 0; checks = 0; n_start = 0; last_tx = 8'h00;
        m_en = 1'b0; m_lat = 3; m_xor = 1'b0; m_fixed = 8'h00;
        m_pend = 1'b0; m_cnt = 0; m_cap = 8'h00; m_done = 1'b0; m_rx = 8'h00;
        inj_done = 1'b0; inj_data = 8'h00;
        bus.wr_valid = 1'b0; bus.wr_data = 8'h00; bus.rd_ready = 1'b0;
        test_reset();
        test_single();
        test_done_in_idle();
        test_fill_stall();
`ifdef SPI_SEQ_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid();
        test_recover();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_txn_sequencer.md
SPI_TXN_SEQUENCER -- requirements
Module: spi_txn_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, TX and RX FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, watchdog limit in clk cycles (used only with SPI_SEQ_TIMEOUT_EN).
REQ-003 SHALL have port clk  in  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port wr_valid  in  1  host offers a TX byte.
REQ-006 SHALL have port wr_data  in  8  TX byte from host.
REQ-007 SHALL have port wr_ready  out  1  TX FIFO not full.
REQ-008 SHALL have port rd_valid  out  1  RX FIFO not empty.
REQ-009 SHALL have port rd_data  out  8  head of RX FIFO.
REQ-010 SHALL have port rd_ready  in  1  host pops RX byte.
REQ-011 SHALL have port spi_start  out  1  one-cycle start pulse to the SPI master.
REQ-012 SHALL have port spi_tx_data  out  8  byte presented to the SPI master.
REQ-013 SHALL have port spi_done  in  1  master transfer-complete pulse.
REQ-014 SHALL have port spi_rx_data  in  8  byte received by the master, valid when spi_done=1.
REQ-015 SHALL have port busy  out  1  FSM not in IDLE.
REQ-016 SHALL have port timeout_err  out  1  sticky watchdog flag (tied 0 without SPI_SEQ_TIMEOUT_EN).

Function
REQ-017 SHALL push wr_data into TX FIFO on any cycle with wr_valid && wr_ready; the byte becomes poppable the next cycle.
REQ-018 SHALL pop RX FIFO on rd_valid && rd_ready; rd_data SHALL be the FIFO head, combinational from storage.
REQ-019 SHALL implement FSM IDLE, LOAD, WAIT_DONE, STORE.
REQ-020 IDLE -> LOAD SHALL occur when TX FIFO non-empty and RX FIFO has at least one free entry; otherwise remain IDLE.
REQ-021 LOAD SHALL pop TX head into spi_tx_data register, assert spi_start for exactly one cycle, then go to WAIT_DONE.
REQ-022 spi_tx_data SHALL hold stable from LOAD until the next LOAD.
REQ-023 WAIT_DONE SHALL capture spi_rx_data on the cycle spi_done=1 and go to STORE; spi_done seen in any other state SHALL be ignored.
REQ-024 STORE SHALL push captured byte into RX FIFO (space guaranteed by REQ-020) and go to IDLE.
REQ-025 Minimum spacing between consecutive spi_start pulses SHALL be 3 clk cycles plus master transfer time.
REQ-026 Both FIFOs SHALL use wrap-around pointers with an extra MSB for full/empty; full-TX SHALL drop wr_ready, and simultaneous host push with FSM pop SHALL both take effect.
REQ-027 Simultaneous RX push (STORE) and host pop SHALL both take effect; count unchanged.

Reset
REQ-028 On reset=0, SHALL asynchronously force FSM to IDLE, empty both FIFOs, and drive spi_start=0, spi_tx_data=8'h00, busy=0, rd_valid=0, wr_ready=1, timeout_err=0.
REQ-029 Reset asserted mid-transfer SHALL discard in-flight and queued bytes; no spi_start until after reset release and a new wr push.

Configuration
REQ-030 With SPI_SEQ_TIMEOUT_EN defined, a counter SHALL run in WAIT_DONE; reaching TIMEOUT_CYCLES SHALL set timeout_err (sticky until reset), push 8'hFF into RX FIFO via STORE, and resume.
REQ-031 Without SPI_SEQ_TIMEOUT_EN, WAIT_DONE SHALL wait indefinitely and timeout_err SHALL be constant 0.

Structure
REQ-032 Package spi_seq_pkg SHALL hold the FSM state typedef, byte width constant 8, and default DEPTH/TIMEOUT_CYCLES.
REQ-033 A sub-module spi_seq_fifo (8-bit, DEPTH-parameterised, async active-low reset) SHALL be instantiated twice, for TX and RX.

Verification
REQ-034 Push 8'hA5 with master+slave model whose slave byte is 8'h3C -> one spi_start pulse, spi_tx_data=8'hA5, rd_data=8'h3C with rd_valid=1 after STORE.
REQ-035 Push 5 bytes back-to-back with DEPTH=4 and rd_ready=0 -> wr_ready low when full; after 4 transfers RX full, FSM stalls in IDLE with 1 byte left in TX; popping one RX byte resumes.
REQ-036 spi_done pulse injected while in IDLE -> no RX push, state unchanged.
REQ-037 reset asserted during WAIT_DONE -> outputs at reset values same cycle, FIFOs empty, no further spi_start.
REQ-038 With SPI_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, spi_done held 0 -> timeout_err=1 after 16 WAIT_DONE cycles, rd_data=8'hFF, next queued byte starts.
